pc_unit: RTL and testbench

Parametrised fetch-stage PC generator replacing the purely combinational next-PC selector. Holds the architectural fetch PC in a register, predicts the next PC from an optional direct-mapped branch target buffer (BTB), resolves the real next PC for the EX-stage instruction, and redirects and flushes on misprediction or misaligned target. It sits between the fetch PC register and instruction memory, and takes resolution inputs from EX.

---
 rtl/pc_unit_pkg.sv | 40 ++++
 rtl/pc_btb.sv | 92 +++++++++
 rtl/pc_unit.sv | 130 +++++++++++++
 tb/tb_pc_unit.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/pc_unit_pkg.sv
// Shared definitions for the fetch-stage PC generator.
//   - PC_SEL_* : EX-stage next-PC selector encodings
//   - btb_entry_t : branch target buffer entry (valid, tag, target, 2-bit counter)
//   - CTR_* : 2-bit saturating counter constants, ctr_update() helper
// BTB fields are BTB_FIELD_W wide; the PC width used with the BTB must not exceed it.
package pc_unit_pkg;

    localparam logic [1:0] PC_SEL_SEQ    = 2'b00;
    localparam logic [1:0] PC_SEL_BRANCH = 2'b01;
    localparam logic [1:0] PC_SEL_JAL    = 2'b10;
    localparam logic [1:0] PC_SEL_JALR   = 2'b11;

    localparam int unsigned BTB_FIELD_W = 32;

    localparam logic [1:0] CTR_MIN          = 2'd0;
    localparam logic [1:0] CTR_WEAK_TAKEN   = 2'd2;
    localparam logic [1:0] CTR_MAX          = 2'd3;
    localparam logic [1:0] CTR_ALLOC_BRANCH = 2'd2;
    localparam logic [1:0] CTR_ALLOC_JUMP   = 2'd3;

    typedef struct packed {
        logic                   valid;
        logic [BTB_FIELD_W-1:0] tag;
        logic [BTB_FIELD_W-1:0] target;
        logic [1:0]             ctr;
    } btb_entry_t;

    // Saturating 2-bit counter step toward taken / not-taken.
    function automatic logic [1:0] ctr_update(input logic [1:0] ctr, input logic taken);
        logic [1:0] res;
        res = ctr;
        if (taken) begin
            if (ctr != CTR_MAX) res = ctr + 2'd1;
        end else begin
            if (ctr != CTR_MIN) res = ctr - 2'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/pc_btb.sv
// Direct-mapped branch target buffer for the fetch PC generator.
// Ports:
//   clk_i, reset_i      clock, synchronous active-high reset (clears valid bits)
//   lookup_pc           fetch PC bits [XLEN-1:2]
//   pred_taken_c        lookup hit with counter in a taken state (combinational)
//   target_c            stored target of the looked-up entry (combinational)
//   upd_en              resolve a control transfer this cycle
//   upd_pc              EX PC bits [XLEN-1:2]
//   upd_taken           resolved direction
//   upd_is_branch       conditional branch (vs. jal/jalr) for allocation strength
//   upd_target          resolved next PC
//   upd_misaligned      resolved target is misaligned; never stored
module pc_btb
    import pc_unit_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 8
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic [XLEN-3:0] lookup_pc,
    output logic            pred_taken_c,
    output logic [XLEN-1:0] target_c,
    input  logic            upd_en,
    input  logic [XLEN-3:0] upd_pc,
    input  logic            upd_taken,
    input  logic            upd_is_branch,
    input  logic [XLEN-1:0] upd_target,
    input  logic            upd_misaligned
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    btb_entry_t mem [DEPTH];

    logic [IDX_W-1:0]      rd_idx;
    logic [XLEN-3-IDX_W:0] rd_tag;
    btb_entry_t            rd_entry;
    logic [IDX_W-1:0]      up_idx;
    logic [XLEN-3-IDX_W:0] up_tag;
    btb_entry_t            up_entry;
    logic                  up_hit;
    logic                  wr_en;
    btb_entry_t            wr_entry;

    // Lookup on the fetch PC; reads see the array before this cycle's write.
    always_comb begin
        rd_idx       = lookup_pc[IDX_W-1:0];
        rd_tag       = lookup_pc[XLEN-3:IDX_W];
        rd_entry     = mem[rd_idx];
        pred_taken_c = rd_entry.valid && (rd_entry.tag == BTB_FIELD_W'(rd_tag))
                       && (rd_entry.ctr >= CTR_WEAK_TAKEN);
        target_c     = XLEN'(rd_entry.target);
    end

    // Update: train on hit, allocate on taken miss, never store misaligned targets.
    always_comb begin
        up_idx   = upd_pc[IDX_W-1:0];
        up_tag   = upd_pc[XLEN-3:IDX_W];
        up_entry = mem[up_idx];
        up_hit   = up_entry.valid && (up_entry.tag == BTB_FIELD_W'(up_tag));
        wr_en    = 1'b0;
        wr_entry = up_entry;
        if (upd_en) begin
            if (up_hit) begin
                wr_en        = 1'b1;
                wr_entry.ctr = ctr_update(up_entry.ctr, upd_taken);
                if (upd_taken && !upd_misaligned) begin
                    wr_entry.target = BTB_FIELD_W'(upd_target);
                end
            end else if (upd_taken && !upd_misaligned) begin
                wr_en           = 1'b1;
                wr_entry.valid  = 1'b1;
                wr_entry.tag    = BTB_FIELD_W'(up_tag);
                wr_entry.target = BTB_FIELD_W'(upd_target);
                wr_entry.ctr    = upd_is_branch ? CTR_ALLOC_BRANCH : CTR_ALLOC_JUMP;
            end
        end
    end

    // Storage; only valid bits are reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i].valid <= 1'b0;
            end
        end else if (wr_en) begin
            mem[up_idx] <= wr_entry;
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Fetch-stage PC generator: fetch PC register, next-PC prediction, EX-stage
// resolution, redirect/flush on mispredict, trap redirect on misaligned target.
// Optional BTB enabled by defining PC_UNIT_BTB_EN; otherwise static not-taken.
// Ports:
//   clk_i, reset_i        clock, synchronous active-high reset
//   stall_i               hold pc_o (redirect still wins)
//   ex_valid_i            EX instruction valid
//   ex_pc_i, ex_pc_sel_i  EX PC and next-PC selector (seq/branch/jal/jalr)
//   ex_offset_i, ex_rs1_i immediate and jalr base
//   ex_branch_i           branch condition
//   ex_pred_target_i      prediction made at fetch for the EX instruction
//   pc_o                  fetch PC (registered)
//   pc_plus_4_o           ex_pc_i + 4 link value (combinational)
//   pred_target_o         predicted next fetch PC (combinational)
//   flush_o, trap_o       mispredict / misaligned target (combinational)
//   mispredict_cnt_o      count of flush cycles
module pc_unit
    import pc_unit_pkg::*;
#(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter logic [XLEN-1:0] TRAP_PC   = '0,
    parameter int unsigned     BTB_DEPTH = 8
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            stall_i,
    input  logic            ex_valid_i,
    input  logic [XLEN-1:0] ex_pc_i,
    input  logic [1:0]      ex_pc_sel_i,
    input  logic [XLEN-1:0] ex_offset_i,
    input  logic [XLEN-1:0] ex_rs1_i,
    input  logic            ex_branch_i,
    input  logic [XLEN-1:0] ex_pred_target_i,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc_plus_4_o,
    output logic [XLEN-1:0] pred_target_o,
    output logic            flush_o,
    output logic            trap_o,
    output logic [31:0]     mispredict_cnt_o
);

    logic [XLEN-1:0] pc_r;
    logic [31:0]     cnt_r;
    logic [XLEN-1:0] seq_pc_c;
    logic [XLEN-1:0] rel_pc_c;
    logic [XLEN-1:0] jalr_sum_c;
    logic [XLEN-1:0] actual_c;
    logic            misaligned_c;
    logic            resolve_c;
    logic [XLEN-1:0] redirect_c;
    logic [XLEN-1:0] fetch_seq_c;

    // Resolve the real next PC of the EX instruction.
    always_comb begin
        seq_pc_c   = ex_pc_i + XLEN'(4);
        rel_pc_c   = ex_pc_i + ex_offset_i;
        jalr_sum_c = ex_rs1_i + ex_offset_i;
        actual_c   = seq_pc_c;
        case (ex_pc_sel_i)
            PC_SEL_SEQ:    actual_c = seq_pc_c;
            PC_SEL_BRANCH: actual_c = ex_branch_i ? rel_pc_c : seq_pc_c;
            PC_SEL_JAL:    actual_c = rel_pc_c;
            PC_SEL_JALR:   actual_c = {jalr_sum_c[XLEN-1:1], 1'b0};
            default:       actual_c = seq_pc_c;
        endcase
        misaligned_c = actual_c[1];
        resolve_c    = ex_valid_i && !reset_i;
        redirect_c   = misaligned_c ? TRAP_PC : actual_c;
        flush_o      = resolve_c && ((actual_c != ex_pred_target_i) || misaligned_c);
        trap_o       = resolve_c && misaligned_c;
        pc_plus_4_o  = seq_pc_c;
        fetch_seq_c  = pc_r + XLEN'(4);
    end

`ifdef PC_UNIT_BTB_EN
    logic            taken_c;
    logic            btb_pred_taken;
    logic [XLEN-1:0] btb_target;

    assign taken_c = (ex_pc_sel_i == PC_SEL_JAL) || (ex_pc_sel_i == PC_SEL_JALR)
                     || ((ex_pc_sel_i == PC_SEL_BRANCH) && ex_branch_i);

    pc_btb #(
        .XLEN  (XLEN),
        .DEPTH (BTB_DEPTH)
    ) u_btb (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .lookup_pc      (pc_r[XLEN-1:2]),
        .pred_taken_c   (btb_pred_taken),
        .target_c       (btb_target),
        .upd_en         (ex_valid_i && (ex_pc_sel_i != PC_SEL_SEQ)),
        .upd_pc         (ex_pc_i[XLEN-1:2]),
        .upd_taken      (taken_c),
        .upd_is_branch  (ex_pc_sel_i == PC_SEL_BRANCH),
        .upd_target     (actual_c),
        .upd_misaligned (misaligned_c)
    );

    assign pred_target_o = btb_pred_taken ? btb_target : fetch_seq_c;
`else
    // Static not-taken prediction.
    assign pred_target_o = fetch_seq_c;
`endif

    // Fetch PC: reset > redirect > stall > prediction.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pc_r <= RESET_PC;
        end else if (flush_o) begin
            pc_r <= redirect_c;
        end else if (!stall_i) begin
            pc_r <= pred_target_o;
        end
    end

    // Mispredict counter, wraps naturally.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_r <= 32'd0;
        end else if (flush_o) begin
            cnt_r <= cnt_r + 32'd1;
        end
    end

    assign pc_o             = pc_r;
    assign mispredict_cnt_o = cnt_r;

endmodule

// File: tb/tb_pc_unit.sv
// Directed table-driven bench for pc_unit (RESET_PC 0x100, TRAP_PC 0x800).
module tb_pc_unit;
    import pc_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [1:0]  ex_sel;
    logic [31:0] ex_off;
    logic [31:0] ex_rs1;
    logic        ex_br;
    logic [31:0] ex_pred;
    logic [31:0] pc;
    logic [31:0] pc_plus_4;
    logic [31:0] pred_target;
    logic        flush;
    logic        trap;
    logic [31:0] mcnt;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pc_unit #(
        .XLEN      (32),
        .RESET_PC  (32'h0000_0100),
        .TRAP_PC   (32'h0000_0800),
        .BTB_DEPTH (8)
    ) dut (
        .clk_i            (clk),
        .reset_i          (reset),
        .stall_i          (stall),
        .ex_valid_i       (ex_valid),
        .ex_pc_i          (ex_pc),
        .ex_pc_sel_i      (ex_sel),
        .ex_offset_i      (ex_off),
        .ex_rs1_i         (ex_rs1),
        .ex_branch_i      (ex_br),
        .ex_pred_target_i (ex_pred),
        .pc_o             (pc),
        .pc_plus_4_o      (pc_plus_4),
        .pred_target_o    (pred_target),
        .flush_o          (flush),
        .trap_o           (trap),
        .mispredict_cnt_o (mcnt)
    );

    typedef struct {
        logic        rst;
        logic        stall;
        logic        v;
        logic [31:0] epc;
        logic [1:0]  sel;
        logic [31:0] off;
        logic [31:0] rs1;
        logic        br;
        logic [31:0] pred;
        logic [31:0] e_pc;
        logic [31:0] e_pt;
        logic [31:0] e_pp4;
        logic        e_flush;
        logic        e_trap;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t tbl [20];

    function automatic vec_t mk(input logic rst, input logic stl, input logic v,
                                input logic [31:0] epc, input logic [1:0] sel,
                                input logic [31:0] off, input logic [31:0] rs1,
                                input logic br, input logic [31:0] pred,
                                input logic [31:0] e_pc, input logic [31:0] e_pt,
                                input logic [31:0] e_pp4, input logic e_f,
                                input logic e_t, input logic [31:0] e_cnt);
        vec_t r;
        r.rst = rst; r.stall = stl; r.v = v; r.epc = epc; r.sel = sel;
        r.off = off; r.rs1 = rs1; r.br = br; r.pred = pred;
        r.e_pc = e_pc; r.e_pt = e_pt; r.e_pp4 = e_pp4;
        r.e_flush = e_f; r.e_trap = e_t; r.e_cnt = e_cnt;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rst, input logic stl, input logic v,
                         input logic [31:0] epc, input logic [1:0] sel,
                         input logic [31:0] off, input logic [31:0] rs1,
                         input logic br, input logic [31:0] pred);
        reset = rst; stall = stl; ex_valid = v; ex_pc = epc; ex_sel = sel;
        ex_off = off; ex_rs1 = rs1; ex_br = br; ex_pred = pred;
    endtask

    // One cycle of EX activity, sampled 1ns after the falling edge.
    task automatic step(input logic rst, input logic v, input logic [31:0] epc,
                        input logic [1:0] sel, input logic [31:0] off,
                        input logic br, input logic [31:0] pred);
        @(negedge clk);
        drive(rst, 1'b0, v, epc, sel, off, 32'h0, br, pred);
        #1;
    endtask

    initial begin
        tbl[0]  = mk(0,0,0, 32'h0,   PC_SEL_SEQ,    32'h0,   32'h0,   0, 32'h0,   32'h100, 32'h104, 32'h4,   0,0, 0);
        tbl[1]  = mk(0,0,0, 32'h0,   PC_SEL_SEQ,    32'h0,   32'h0,   0, 32'h0,   32'h104, 32'h108, 32'h4,   0,0, 0);
        tbl[2]  = mk(0,0,0, 32'h0,   PC_SEL_SEQ,    32'h0,   32'h0,   0, 32'h0,   32'h108, 32'h10C, 32'h4,   0,0, 0);
        tbl[3]  = mk(0,0,1, 32'h104, PC_SEL_JAL,    32'h40,  32'h0,   0, 32'h108, 32'h10C, 32'h110, 32'h108, 1,0, 0);
        tbl[4]  = mk(0,0,0, 32'h0,   PC_SEL_SEQ,    32'h0,   32'h0,   0, 32'h0,   32'h144, 32'h148, 32'h4,   0,0, 1);
        tbl[5]  = mk(0,0,1, 32'h144, PC_SEL_SEQ,    32'h0,   32'h0,   0, 32'h148, 32'h148, 32'h14C, 32'h148, 0,0, 1);
        tbl[6]  = mk(0,0,1, 32'h148, PC_SEL_BRANCH, 32'h100, 32'h0,   0, 32'h14C, 32'h14C, 32'h150, 32'h14C, 0,0, 1);
        tbl[7]  = mk(0,0,1, 32'h14C, PC_SEL_BRANCH, 32'hFFFF_FFF8, 32'h0, 1, 32'h150, 32'h150, 32'h154, 32'h150, 1,0, 1);
        tbl[8]  = mk(0,0,1, 32'h100, PC_SEL_JALR,   32'h0,   32'h201, 0, 32'h104, 32'h144, 32'h148, 32'h104, 1,0, 2);
        tbl[9]  = mk(0,0,1, 32'h100, PC_SEL_JALR,   32'h0,   32'h202, 0, 32'h202, 32'h200, 32'h204, 32'h104, 1,1, 3);
        tbl[10] = mk(0,1,1, 32'h200, PC_SEL_JAL,    32'h100, 32'h0,   0, 32'h204, 32'h800, 32'h804, 32'h204, 1,0, 4);
        tbl[11] = mk(0,1,0, 32'h0,   PC_SEL_SEQ,    32'h0,   32'h0,   0, 32'h0,   32'h300, 32'h304, 32'h4,   0,0, 5);
        tbl[12] = mk(0,1,0, 32'h0,   PC_SEL_SEQ,    32'h0,   32'h0,   0, 32'h0,   32'h300, 32'h304, 32'h4,   0,0, 5);
        tbl[13] = mk(0,0,0, 32'h0,   PC_SEL_SEQ,    32'h0,   32'h0,   0, 32'h0,   32'h300, 32'h304, 32'h4,   0,0, 5);
        tbl[14] = mk(0,0,0, 32'h0,   PC_SEL_SEQ,    32'h0,   32'h0,   0, 32'h0,   32'h304, 32'h308, 32'h4,   0,0, 5);
        tbl[15] = mk(0,0,1, 32'h300, PC_SEL_BRANCH, 32'h20,  32'h0,   1, 32'h320, 32'h308, 32'h30C, 32'h304, 0,0, 5);
        tbl[16] = mk(0,0,1, 32'hFFFF_FFFC, PC_SEL_JAL, 32'h8, 32'h0,  0, 32'h0,   32'h30C, 32'h310, 32'h0,   1,0, 5);
        tbl[17] = mk(0,0,0, 32'h100, PC_SEL_JAL,    32'h40,  32'h0,   0, 32'h0,   32'h4,   32'h8,   32'h104, 0,0, 6);
        tbl[18] = mk(1,0,1, 32'h100, PC_SEL_JALR,   32'h0,   32'h202, 0, 32'h202, 32'h8,   32'hC,   32'h104, 0,0, 6);
        tbl[19] = mk(0,0,0, 32'h0,   PC_SEL_SEQ,    32'h0,   32'h0,   0, 32'h0,   32'h100, 32'h104, 32'h4,   0,0, 0);

        // Reset with a misaligned, mispredicted jalr in EX: no flush, no trap.
        drive(1'b1, 1'b0, 1'b1, 32'h100, PC_SEL_JALR, 32'h0, 32'h202, 1'b0, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_flush", 32'(flush), 32'h0);
        chk("rst_trap",  32'(trap),  32'h0);
        chk("rst_pc",    pc,         32'h100);
        chk("rst_cnt",   mcnt,       32'h0);

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            drive(tbl[i].rst, tbl[i].stall, tbl[i].v, tbl[i].epc, tbl[i].sel,
                  tbl[i].off, tbl[i].rs1, tbl[i].br, tbl[i].pred);
            #1;
            chk($sformatf("v%0d_pc", i),    pc,           tbl[i].e_pc);
            chk($sformatf("v%0d_pred", i),  pred_target,  tbl[i].e_pt);
            chk($sformatf("v%0d_pp4", i),   pc_plus_4,    tbl[i].e_pp4);
            chk($sformatf("v%0d_flush", i), 32'(flush),   32'(tbl[i].e_flush));
            chk($sformatf("v%0d_trap", i),  32'(trap),    32'(tbl[i].e_trap));
            chk($sformatf("v%0d_cnt", i),   mcnt,         tbl[i].e_cnt);
        end

`ifdef PC_UNIT_BTB_EN
        // Train branch at 0x10 -> 0x80, then weaken it with two not-taken results.
        step(0, 1, 32'h0,  PC_SEL_JAL,    32'h10, 0, 32'h4);
        chk("btb_a_flush0", 32'(flush), 32'h1);
        step(0, 1, 32'h10, PC_SEL_BRANCH, 32'h70, 1, 32'h14);
        chk("btb_a_pc10",   pc,          32'h10);
        chk("btb_a_cold",   pred_target, 32'h14);
        step(0, 1, 32'h40, PC_SEL_JAL,    32'hFFFF_FFD0, 0, 32'h44);
        chk("btb_a_pc80",   pc,          32'h80);
        step(0, 1, 32'h10, PC_SEL_BRANCH, 32'h70, 0, 32'h80);
        chk("btb_a_pc10b",  pc,          32'h10);
        chk("btb_a_hit",    pred_target, 32'h80);
        chk("btb_a_nt1",    32'(flush),  32'h1);
        step(0, 1, 32'h10, PC_SEL_BRANCH, 32'h70, 0, 32'h14);
        chk("btb_a_pc14",   pc,          32'h14);
        chk("btb_a_nt2",    32'(flush),  32'h0);
        step(0, 1, 32'h40, PC_SEL_JAL,    32'hFFFF_FFD0, 0, 32'h44);
        step(0, 0, 32'h0,  PC_SEL_SEQ,    32'h0,  0, 32'h0);
        chk("btb_a_pc10c",  pc,          32'h10);
        chk("btb_a_weak",   pred_target, 32'h14);

        // Alias: 0x10 and 0x30 share index 4; second allocation evicts the first.
        step(1, 0, 32'h0,  PC_SEL_SEQ,    32'h0,  0, 32'h0);
        step(0, 1, 32'h10, PC_SEL_BRANCH, 32'h70, 1, 32'h14);
        chk("btb_b_pc100",  pc,          32'h100);
        step(0, 1, 32'h40, PC_SEL_JAL,    32'hFFFF_FFD0, 0, 32'h44);
        chk("btb_b_pc80",   pc,          32'h80);
        step(0, 1, 32'h30, PC_SEL_BRANCH, 32'h50, 1, 32'h34);
        chk("btb_b_pc10",   pc,          32'h10);
        chk("btb_b_hit",    pred_target, 32'h80);
        step(0, 1, 32'h40, PC_SEL_JAL,    32'hFFFF_FFD0, 0, 32'h44);
        chk("btb_b_pc80b",  pc,          32'h80);
        step(0, 0, 32'h0,  PC_SEL_SEQ,    32'h0,  0, 32'h0);
        chk("btb_b_pc10b",  pc,          32'h10);
        chk("btb_b_evict",  pred_target, 32'h14);
`endif

        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 32'h0, PC_SEL_SEQ, 32'h0, 32'h0, 1'b0, 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
